// File: rtl/unary_stream_gen_pkg.sv
// Shared types and constants for the unary stream generator and the serial unary adder.
package unary_stream_gen_pkg;

    localparam int WIDTH = 4;
    localparam int LEN   = 16;
    localparam int DRAIN = 20;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/unary_thermo_cmp.sv
// Thermometer-code bit: high while the stream index is below the operand value.
module unary_thermo_cmp #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] val,
    output logic             thermo
);

    assign thermo = (cnt < val);

endmodule

// File: rtl/unary_stream_gen.sv
// Serialises two binary operands as unary streams, then holds read_or_write for the adder readout.
module unary_stream_gen #(
    parameter int WIDTH = unary_stream_gen_pkg::WIDTH,
    parameter int LEN   = unary_stream_gen_pkg::LEN,
    parameter int DRAIN = unary_stream_gen_pkg::DRAIN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_bin,
    input  logic [WIDTH-1:0] b_bin,
    input  logic             abort,
    output logic             ready,
    output logic             A,
    output logic             B,
    output logic             en,
    output logic             read_or_write,
    output logic             done
);

    import unary_stream_gen_pkg::*;

    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [WIDTH-1:0] CNT_LAST  = WIDTH'(LEN - 1);
    localparam logic [DW-1:0]    DCNT_LAST = DW'(DRAIN - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             ready_q, ready_d;
    logic             a_bit_q, a_bit_d, b_bit_q, b_bit_d;
    logic             en_q, en_d;
    logic             rw_q, rw_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] cmp_cnt, cmp_a_val, cmp_b_val;
    logic             a_thermo, b_thermo;

    unary_thermo_cmp #(.WIDTH(WIDTH)) u_cmp_a (
        .cnt    (cmp_cnt),
        .val    (cmp_a_val),
        .thermo (a_thermo)
    );

    unary_thermo_cmp #(.WIDTH(WIDTH)) u_cmp_b (
        .cnt    (cmp_cnt),
        .val    (cmp_b_val),
        .thermo (b_thermo)
    );

    // Comparators look one index ahead so the registered stream bit lands on the right cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dcnt_d    = dcnt_q;
        a_d       = a_q;
        b_d       = b_q;
        ready_d   = ready_q;
        a_bit_d   = a_bit_q;
        b_bit_d   = b_bit_q;
        en_d      = en_q;
        rw_d      = rw_q;
        done_d    = 1'b0;
        cmp_cnt   = cnt_q + 1'b1;
        cmp_a_val = a_q;
        cmp_b_val = b_q;

        unique case (state_q)
            ST_IDLE: begin
                cmp_cnt   = '0;
                cmp_a_val = a_bin;
                cmp_b_val = b_bin;
                if (start) begin
                    state_d = ST_STREAM;
                    a_d     = a_bin;
                    b_d     = b_bin;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    en_d    = 1'b1;
                    a_bit_d = a_thermo;
                    b_bit_d = b_thermo;
                    rw_d    = RW_READ;
                end
            end
            ST_STREAM: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DRAIN;
                    en_d    = 1'b0;
                    a_bit_d = 1'b0;
                    b_bit_d = 1'b0;
                    rw_d    = RW_WRITE;
                    dcnt_d  = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    a_bit_d = a_thermo;
                    b_bit_d = b_thermo;
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == DCNT_LAST) begin
                    state_d = ST_IDLE;
                    rw_d    = RW_READ;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            dcnt_d  = '0;
            ready_d = 1'b1;
            a_bit_d = 1'b0;
            b_bit_d = 1'b0;
            en_d    = 1'b0;
            rw_d    = RW_READ;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ready_q <= 1'b1;
            a_bit_q <= 1'b0;
            b_bit_q <= 1'b0;
            en_q    <= 1'b0;
            rw_q    <= RW_READ;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ready_q <= ready_d;
            a_bit_q <= a_bit_d;
            b_bit_q <= b_bit_d;
            en_q    <= en_d;
            rw_q    <= rw_d;
            done_q  <= done_d;
        end
    end

    assign ready         = ready_q;
    assign A             = a_bit_q;
    assign B             = b_bit_q;
    assign en            = en_q;
    assign read_or_write = rw_q;
    assign done          = done_q;

endmodule

// File: tb/tb_unary_stream_gen.sv
// Scoreboard bench for unary_stream_gen: per-cycle expected output vectors queued at stimulus time.
module tb_unary_stream_gen;

    localparam int WIDTH = 4;
    localparam int LEN   = 16;
    localparam int DRAIN = 20;
    localparam int TXN   = LEN + DRAIN + 1;
    localparam logic [5:0] IDLE_V = 6'b100000;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_bin;
    logic [WIDTH-1:0] b_bin;
    logic             abort;
    logic             ready;
    logic             A;
    logic             B;
    logic             en;
    logic             read_or_write;
    logic             done;

    unary_stream_gen #(.WIDTH(WIDTH), .LEN(LEN), .DRAIN(DRAIN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .a_bin         (a_bin),
        .b_bin         (b_bin),
        .abort         (abort),
        .ready         (ready),
        .A             (A),
        .B             (B),
        .en            (en),
        .read_or_write (read_or_write),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               ea;
        int               eb;
        int               esum;
    } vec_t;

    vec_t       tbl[4];
    logic [5:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         ones_a, ones_b, sum;

    // Expected {ready, A, B, en, read_or_write, done} for cycle n after acceptance.
    function automatic logic [5:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int n);
        if (n < LEN)
            return {1'b0, (n < a), (n < b), 1'b1, 1'b0, 1'b0};
        else if (n < LEN + DRAIN)
            return 6'b000010;
        else
            return 6'b100001;
    endfunction

    function automatic logic [5:0] obs();
        return {ready, A, B, en, read_or_write, done};
    endfunction

    task automatic check_vec(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t act=%b exp=%b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic push_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int upto);
        for (int n = 0; n < upto; n++) exp_q.push_back(model(a, b, n));
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(IDLE_V);
    endtask

    task automatic clear_counts();
        ones_a = 0;
        ones_b = 0;
        sum    = 0;
    endtask

    // Pops and compares one expected vector per cycle; also acts as the bench adder.
    task automatic drain_q(input string name, input int n, input bit release_start);
        logic [5:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s scoreboard empty act=%b", name, obs());
            end else begin
                e = exp_q.pop_front();
                check_vec(name, obs(), e);
            end
            if (en === 1'b1) begin
                ones_a += int'(A);
                ones_b += int'(B);
                sum    += int'(A) + int'(B);
            end
            if (i == 0 && release_start) begin
                start = 1'b0;
                abort = 1'b0;
            end
        end
    endtask

    initial begin
        tbl[0] = '{a: 4'd15, b: 4'd3,  ea: 15, eb: 3,  esum: 18};
        tbl[1] = '{a: 4'd0,  b: 4'd0,  ea: 0,  eb: 0,  esum: 0};
        tbl[2] = '{a: 4'd1,  b: 4'd14, ea: 1,  eb: 14, esum: 15};
        tbl[3] = '{a: 4'd8,  b: 4'd8,  ea: 8,  eb: 8,  esum: 16};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        a_bin = '0;
        b_bin = '0;

        push_idle(2);
        drain_q("reset_hold", 2, 1'b0);
        rst_n = 1'b1;
        push_idle(4);
        drain_q("idle_after_reset", 4, 1'b0);

        for (int v = 0; v < 4; v++) begin
            a_bin = tbl[v].a;
            b_bin = tbl[v].b;
            start = 1'b1;
            clear_counts();
            push_txn(tbl[v].a, tbl[v].b, TXN);
            drain_q("table_txn", TXN, 1'b1);
            check_int("table_ones_a", ones_a, tbl[v].ea);
            check_int("table_ones_b", ones_b, tbl[v].eb);
            check_int("table_adder_sum", sum, tbl[v].esum);
        end

        // start held high: the second acceptance must land exactly TXN edges after the first
        a_bin = 4'd5;
        b_bin = 4'd7;
        start = 1'b1;
        clear_counts();
        push_txn(4'd5, 4'd7, TXN);
        push_txn(4'd9, 4'd2, TXN);
        drain_q("hold_first", 1, 1'b0);
        a_bin = 4'd9;
        b_bin = 4'd2;
        drain_q("hold_first", TXN - 1, 1'b0);
        check_int("hold_first_ones_a", ones_a, 5);
        check_int("hold_first_ones_b", ones_b, 7);
        clear_counts();
        drain_q("hold_second", TXN, 1'b1);
        check_int("hold_second_ones_a", ones_a, 9);
        check_int("hold_second_ones_b", ones_b, 2);

        // abort at stream cycle 6, then start+abort together in IDLE
        a_bin = 4'd10;
        b_bin = 4'd10;
        start = 1'b1;
        push_txn(4'd10, 4'd10, 7);
        drain_q("abort_pre", 7, 1'b1);
        abort = 1'b1;
        push_idle(1);
        drain_q("abort_post", 1, 1'b0);
        a_bin = 4'd3;
        b_bin = 4'd4;
        start = 1'b1;
        clear_counts();
        push_txn(4'd3, 4'd4, TXN);
        drain_q("after_abort_txn", TXN, 1'b1);
        check_int("after_abort_ones_a", ones_a, 3);
        check_int("after_abort_ones_b", ones_b, 4);

        // asynchronous reset at drain cycle 4
        a_bin = 4'd6;
        b_bin = 4'd6;
        start = 1'b1;
        push_txn(4'd6, 4'd6, LEN + 5);
        drain_q("rst_pre", LEN + 5, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("rst_async", obs(), IDLE_V);
        @(negedge clk);
        check_vec("rst_held", obs(), IDLE_V);
        rst_n = 1'b1;
        push_idle(6);
        drain_q("rst_post_idle", 6, 1'b0);

        check_int("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
